// File: rtl/pc_sequencer.sv
// Run/halt/step controller for the program counter: issues the one-cycle fetch
// increment pulse from a programmable prescaler and stops on an address breakpoint.
module pc_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DIV_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_run,
  input  logic                  i_halt,
  input  logic                  i_step,
  input  logic [DIV_WIDTH-1:0]  i_divisor,
  input  logic                  i_bp_enable,
  input  logic [ADDR_WIDTH-1:0] i_bp_addr,
  output logic                  o_inc,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [1:0]            o_state,
  output logic                  o_break
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic                  run_prev_q, run_prev_d;
  logic                  step_prev_q, step_prev_d;
  logic                  run_edge_q, run_edge_d;
  logic                  step_edge_q, step_edge_d;
  logic [DIV_WIDTH-1:0]  presc_q, presc_d;
  logic                  inc_q, inc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  break_q, break_d;
  logic                  fire_s;
  logic                  bp_hit_s;

  // Edge history, address tracking and breakpoint compare
  always_comb begin
    run_prev_d  = i_run;
    step_prev_d = i_step;
    run_edge_d  = i_run & ~run_prev_q;
    step_edge_d = i_step & ~step_prev_q;
    addr_d      = inc_q ? (addr_q + ADDR_ONE) : addr_q;
    fire_s      = (presc_q >= i_divisor);
    // addr_d is the address seen while the new pulse is high; the pulse fetches addr_d+1
    bp_hit_s    = i_bp_enable && ((addr_d + ADDR_ONE) == i_bp_addr);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    inc_d   = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (i_halt) begin
          state_d = ST_HALT;
        end else if (run_edge_q) begin
          state_d = ST_RUN;
        end else if (step_edge_q) begin
          state_d = ST_STEP;
          inc_d   = 1'b1;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          state_d = ST_HALT;
        end else if (fire_s) begin
          inc_d   = 1'b1;
          state_d = bp_hit_s ? ST_BREAK : ST_RUN;
        end else begin
          presc_d = presc_q + DIV_ONE;
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
      ST_BREAK: begin
        if (i_halt) begin
          state_d = ST_HALT;
        end else if (run_edge_q) begin
          state_d = ST_RUN;
        end else if (step_edge_q) begin
          state_d = ST_STEP;
          inc_d   = 1'b1;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    break_d = (state_d == ST_BREAK);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_HALT;
      run_prev_q  <= 1'b0;
      step_prev_q <= 1'b0;
      run_edge_q  <= 1'b0;
      step_edge_q <= 1'b0;
      presc_q     <= '0;
      inc_q       <= 1'b0;
      addr_q      <= '0;
      break_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_prev_q  <= run_prev_d;
      step_prev_q <= step_prev_d;
      run_edge_q  <= run_edge_d;
      step_edge_q <= step_edge_d;
      presc_q     <= presc_d;
      inc_q       <= inc_d;
      addr_q      <= addr_d;
      break_q     <= break_d;
    end
  end

  assign o_inc   = inc_q;
  assign o_addr  = addr_q;
  assign o_state = state_q;
  assign o_break = break_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model of the run/step/break rules.
module tb_pc_sequencer;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int AMOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0, halt = 1'b0, step = 1'b0, bp_en = 1'b0;
  logic [DW-1:0] div = '0;
  logic [AW-1:0] bp_addr = '0;
  logic          inc, brk;
  logic [AW-1:0] addr;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;
  int pulses_seen = 0;

  // Model: mode 0=halt 1=run 2=step 3=break, events seen one edge late
  int     m_mode, m_addr, m_inc;
  longint m_elapsed;
  bit     m_prev_run, m_prev_step, m_run_evt, m_step_evt;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_WIDTH(AW), .DIV_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_halt(halt), .i_step(step),
    .i_divisor(div), .i_bp_enable(bp_en), .i_bp_addr(bp_addr),
    .o_inc(inc), .o_addr(addr), .o_state(state), .o_break(brk)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_addr = 0; m_inc = 0; m_elapsed = 0;
    m_prev_run = 1'b0; m_prev_step = 1'b0; m_run_evt = 1'b0; m_step_evt = 1'b0;
  endfunction

  function automatic void model_step();
    int new_addr;
    int nm;
    int ni;
    new_addr = (m_addr + m_inc) % AMOD;
    nm = m_mode;
    ni = 0;
    if (m_mode == 2) begin
      nm = 0;
    end else if (halt) begin
      nm = 0;
    end else if (m_mode == 1) begin
      if (m_elapsed >= longint'(div)) begin
        ni = 1;
        m_elapsed = 0;
        if (bp_en && ((new_addr + 1) % AMOD) == int'(bp_addr)) nm = 3;
      end else begin
        m_elapsed++;
      end
    end else if (m_run_evt) begin
      nm = 1;
      m_elapsed = 0;
    end else if (m_step_evt) begin
      nm = 2;
      ni = 1;
    end
    m_mode = nm;
    m_inc = ni;
    m_addr = new_addr;
    m_run_evt  = run && !m_prev_run;
    m_step_evt = step && !m_prev_step;
    m_prev_run  = run;
    m_prev_step = step;
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_val("inc", {31'd0, inc}, m_inc);
    check_val("addr", {24'd0, addr}, m_addr);
    check_val("state", {30'd0, state}, m_mode);
    check_val("break", {31'd0, brk}, (m_mode == 3) ? 32'd1 : 32'd0);
    if (inc) pulses_seen++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    cycle();
    run = 1'b0;
  endtask

  task automatic run_to_break(input logic [AW-1:0] target);
    div = 32'd0; bp_en = 1'b1; bp_addr = target;
    pulse_run();
    pulses_seen = 0;
    for (int i = 0; i < 400 && state != 2'd3; i++) cycle();
    cycle();
  endtask

  initial begin
    model_reset();
    repeat (2) cycle();
    check_val("reset_state", {30'd0, state}, 32'd0);
    rst_n = 1'b1;

    // Run at divisor 3
    div = 32'd3;
    pulse_run();
    cycle();
    check_val("run_entry", {30'd0, state}, 32'd1);
    repeat (21) cycle();
    check_val("run_addr5", {24'd0, addr}, 32'd5);
    halt = 1'b1; cycle(); halt = 1'b0; cycle();

    // Three single steps
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; cycle(); step = 1'b0;
      cycle();
      check_val("step_inc", {31'd0, inc}, 32'd1);
      check_val("step_state", {30'd0, state}, 32'd2);
      cycle();
      check_val("step_back", {30'd0, state}, 32'd0);
      repeat (2) cycle();
    end
    check_val("step_addr", {24'd0, addr}, 32'd8);

    // Breakpoint at 6 then resume
    do_reset();
    run_to_break(8'd6);
    check_val("bp_pulses", pulses_seen, 32'd6);
    check_val("bp_state", {30'd0, state}, 32'd3);
    check_val("bp_break", {31'd0, brk}, 32'd1);
    check_val("bp_addr", {24'd0, addr}, 32'd6);
    pulse_run();
    repeat (3) cycle();
    check_val("resume_addr", {24'd0, addr}, 32'd7);
    halt = 1'b1; cycle(); halt = 1'b0; bp_en = 1'b0; cycle();

    // Halt and run rise together in HALT
    halt = 1'b1; run = 1'b1;
    repeat (2) cycle();
    check_val("halt_wins", {30'd0, state}, 32'd0);
    halt = 1'b0; run = 1'b0; cycle();

    // Halt on the prescaler match cycle
    div = 32'd3;
    pulse_run();
    repeat (4) cycle();
    halt = 1'b1; cycle();
    check_val("halt_match_inc", {31'd0, inc}, 32'd0);
    check_val("halt_match_st", {30'd0, state}, 32'd0);
    halt = 1'b0; cycle();

    // Address wrap via a break at 255 then a step
    do_reset();
    run_to_break(8'd255);
    check_val("wrap_pre", {24'd0, addr}, 32'd255);
    bp_en = 1'b0;
    step = 1'b1; cycle(); step = 1'b0;
    repeat (2) cycle();
    check_val("wrap_addr", {24'd0, addr}, 32'd0);

    // Live divisor reduction
    div = 32'd100;
    pulse_run();
    repeat (51) cycle();
    div = 32'd10;
    cycle();
    check_val("div_cut_fire", {31'd0, inc}, 32'd1);
    repeat (10) cycle();
    check_val("div_cut_gap", {31'd0, inc}, 32'd0);
    cycle();
    check_val("div_cut_period", {31'd0, inc}, 32'd1);
    halt = 1'b1; cycle(); halt = 1'b0;

    // Async reset while in BREAK
    do_reset();
    run_to_break(8'd6);
    check_val("pre_rst_addr", {24'd0, addr}, 32'd6);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("arst_state", {30'd0, state}, 32'd0);
    check_val("arst_break", {31'd0, brk}, 32'd0);
    check_val("arst_addr", {24'd0, addr}, 32'd0);
    check_val("arst_inc", {31'd0, inc}, 32'd0);
    cycle();
    rst_n = 1'b1;
    bp_en = 1'b0;

    // Random stimulus
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      if ($urandom_range(0, 14) == 0) step = ~step;
      halt = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) div = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) begin
        bp_en = 1'($urandom_range(0, 1));
        bp_addr = 8'((m_addr + int'($urandom_range(1, 8))) % AMOD);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
